// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-flop line synchroniser and 3-sample mid-bit majority voter
module uart_rx_sampler import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 217,
  localparam int CW = $clog2(CLKS_PER_BIT)
) (
  input  logic          i_Clock,
  input  logic          i_Reset_n,
  input  logic          i_Rx_Serial,
  input  logic [CW-1:0] i_Cnt,
  output logic          o_Rx_S,
  output logic          o_Bit_Valid,
  output logic          o_Bit_Value
);
  localparam int M = (CLKS_PER_BIT - 1) / 2;
  logic [1:0] sync_q, sync_d, samp_q, samp_d;
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sync_q <= 2'b11;
      samp_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
      samp_q <= samp_d;
    end
  end
  always_comb begin
    sync_d = {sync_q[0], i_Rx_Serial};
    samp_d = {(i_Cnt == CW'(M)) ? sync_q[1] : samp_q[1],
              (i_Cnt == CW'(M - 1)) ? sync_q[1] : samp_q[0]};
  end
  // the third sample is the live line at the decision point
  always_comb begin
    o_Rx_S      = sync_q[1];
    o_Bit_Valid = i_Cnt == CW'(M + 1);
    o_Bit_Value = maj3(samp_q[0], samp_q[1], sync_q[1]);
  end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: configurable UART receiver with voted sampling and a ready/valid holding register
module uart_rx_frame import uart_pkg::*; #(
  parameter int      CLKS_PER_BIT = 217,
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY_MODE  = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ready,
  input  logic                 i_Clear_Err,
  output logic                 o_Rx_Valid,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  output logic                 o_Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic par_bit_q, par_bit_d, stop0_q, stop0_d, ferr_q, ferr_d;
  logic valid_q, valid_d, perr_q, perr_d, frame_q, frame_d, brk_q, brk_d, ovr_q, ovr_d, busy_q, busy_d;
  logic rx_s, bit_valid, bit_value, end_bit, last_data, last_stop, done, hold_full, load;
  logic perr_w, frame_w, brk_w;

  uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .i_Clock     (i_Clock),
    .i_Reset_n   (i_Reset_n),
    .i_Rx_Serial (i_Rx_Serial),
    .i_Cnt       (cnt_q),
    .o_Rx_S      (rx_s),
    .o_Bit_Valid (bit_valid),
    .o_Bit_Value (bit_value)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      stop0_q   <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      frame_q   <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_bit_q <= par_bit_d;
      stop0_q   <= stop0_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      frame_q   <= frame_d;
      brk_q     <= brk_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    end_bit   = cnt_q == CW'(CLKS_PER_BIT - 1);
    last_data = idx_q == 4'(DATA_BITS - 1);
    last_stop = idx_q == 4'(STOP_BITS - 1);
  end

  // a word completes at the decision point of its last stop bit, not at the end of that bit
  always_comb begin
    state_d = state_q;
    cnt_d   = end_bit ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: state_d = (bit_valid && bit_value) ? IDLE : end_bit ? DATA : START;
      DATA: if (end_bit) begin
        idx_d = last_data ? '0 : idx_q + 1'b1;
        state_d = !last_data ? DATA : (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
      end
      PARITY: state_d = end_bit ? STOP : PARITY;
      STOP: if (bit_valid && last_stop) begin
        done = 1'b1;
        state_d = bit_value ? IDLE : WAIT_HIGH;
      end else if (end_bit) begin
        idx_d = idx_q + 1'b1;
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : WAIT_HIGH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d   = (state_q == DATA && bit_valid) ? {bit_value, shift_q[DATA_BITS-1:1]} : shift_q;
    par_bit_d = (state_q == PARITY && bit_valid) ? bit_value : par_bit_q;
    stop0_d   = (state_q == STOP && bit_valid && idx_q == '0) ? bit_value : stop0_q;
    ferr_d    = (state_q == IDLE) ? 1'b0 : (state_q == STOP && bit_valid && !bit_value) ? 1'b1 : ferr_q;
    perr_w    = (PARITY_MODE != PAR_NONE) && ((^shift_q ^ par_bit_q) != (PARITY_MODE == PAR_ODD));
    frame_w   = ferr_q | ~bit_value;
    brk_w     = (shift_q == '0) && (PARITY_MODE == PAR_NONE || !par_bit_q) &&
                !((idx_q == '0) ? bit_value : stop0_q);
    hold_full = valid_q && !i_Rx_Ready;
    load      = done && !hold_full;
    valid_d   = load || hold_full;
    ovr_d     = (done && hold_full) || (ovr_q && !i_Clear_Err);
    data_d    = load ? shift_q : data_q;
    perr_d    = load ? perr_w : perr_q;
    frame_d   = load ? frame_w : frame_q;
    brk_d     = load ? brk_w : brk_q;
    busy_d    = state_d != IDLE;
  end

  always_comb begin
    o_Rx_Valid   = valid_q;
    o_Rx_Data    = data_q;
    o_Parity_Err = perr_q;
    o_Frame_Err  = frame_q;
    o_Break      = brk_q;
    o_Overrun    = ovr_q;
    o_Busy       = busy_q;
  end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed checks of uart_rx_frame in 8E1, 8O1, 7N2 and 8N1 builds at 16 clocks per bit
module tb_uart_rx_frame;
  import uart_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic rx [4], rdy [4], valid [4], perr [4], ferr [4], brk [4], ovr [4], busy [4];
  logic [8:0] dout [4];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int DB = (g == 2) ? 7 : 8;
    localparam parity_t PM = (g == 0) ? PAR_EVEN : (g == 1) ? PAR_ODD : PAR_NONE;
    localparam int SB = (g == 2) ? 2 : 1;
    logic [DB-1:0] d;
    uart_rx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(DB), .PARITY_MODE(PM), .STOP_BITS(SB)) dut (
      .i_Clock      (clk),
      .i_Reset_n    (rst_n),
      .i_Rx_Serial  (rx[g]),
      .i_Rx_Ready   (rdy[g]),
      .i_Clear_Err  (clr),
      .o_Rx_Valid   (valid[g]),
      .o_Rx_Data    (d),
      .o_Parity_Err (perr[g]),
      .o_Frame_Err  (ferr[g]),
      .o_Break      (brk[g]),
      .o_Overrun    (ovr[g]),
      .o_Busy       (busy[g])
    );
    assign dout[g] = 9'(d);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int k, input logic [15:0] v, input int n, input int spk = -1);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 16; j++) begin
        rx[k] = (i == spk && j == 8) ? ~v[i] : v[i];
        @(negedge clk);
      end
  endtask

  task automatic get_word(input int k, input logic [8:0] d, input logic pe, input logic fe, input logic bk);
    int t = 0;
    while (!valid[k] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("valid", valid[k], 1);
    check("data", dout[k], d);
    check("parity_err", perr[k], pe);
    check("frame_err", ferr[k], fe);
    check("break", brk[k], bk);
    rdy[k] = 1'b1;
    @(negedge clk);
    rdy[k] = 1'b0;
    check("consumed", valid[k], 0);
  endtask

  task automatic all_zero(input int k);
    check("rst_valid", valid[k], 0);
    check("rst_data", dout[k], 0);
    check("rst_perr", perr[k], 0);
    check("rst_ferr", ferr[k], 0);
    check("rst_brk", brk[k], 0);
    check("rst_ovr", ovr[k], 0);
    check("rst_busy", busy[k], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rx[i] = 1'b1;
      rdy[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    all_zero(3);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send(0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    get_word(0, 9'hA5, 0, 0, 0);
    check("busy_after_8e1", busy[0], 0);

    send(1, {1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    get_word(1, 9'h3C, 1, 0, 0);

    send(2, {1'b0, 1'b1, 7'h55, 1'b0}, 10);
    get_word(2, 9'h55, 0, 1, 0);
    repeat (32) @(negedge clk);
    check("wait_high_busy", busy[2], 1);
    rx[2] = 1'b1;
    repeat (5) @(negedge clk);
    check("wait_high_exit", busy[2], 0);

    rx[3] = 1'b0;
    repeat (320) @(negedge clk);
    get_word(3, 9'h00, 0, 1, 1);
    check("break_one_word", ovr[3], 0);
    check("break_still_busy", busy[3], 1);
    rx[3] = 1'b1;
    repeat (32) @(negedge clk);
    check("break_no_second", valid[3], 0);
    check("break_idle", busy[3], 0);
    send(3, {1'b1, 8'h81, 1'b0}, 10);
    get_word(3, 9'h81, 0, 0, 0);

    rx[3] = 1'b0;
    repeat (3) @(negedge clk);
    rx[3] = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_start", busy[3], 1);
    repeat (30) @(negedge clk);
    check("glitch_abort", busy[3], 0);
    check("glitch_no_word", valid[3], 0);

    send(0, {1'b1, 1'b0, 8'h5A, 1'b0}, 11, 3);
    get_word(0, 9'h5A, 0, 0, 0);

    send(3, {1'b1, 8'h11, 1'b0}, 10);
    send(3, {1'b1, 8'h22, 1'b0}, 10);
    repeat (4) @(negedge clk);
    check("ovr_valid", valid[3], 1);
    check("ovr_held", dout[3], 9'h11);
    check("ovr_set", ovr[3], 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovr_clear", ovr[3], 0);
    check("ovr_still_held", dout[3], 9'h11);
    fork
      send(3, {1'b1, 8'h33, 1'b0}, 10);
      begin
        repeat (155) @(negedge clk);
        check("pre_swap_held", dout[3], 9'h11);
        rdy[3] = 1'b1;
        @(negedge clk);
        rdy[3] = 1'b0;
        check("swap_valid", valid[3], 1);
        check("swap_data", dout[3], 9'h33);
        check("swap_no_ovr", ovr[3], 0);
      end
    join
    repeat (4) @(negedge clk);

    send(3, {8'h5A, 1'b0}, 5);
    rx[3] = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_frame_busy", busy[3], 1);
    rst_n = 1'b0;
    #1;
    all_zero(3);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_idle", busy[3], 0);
    send(3, {1'b1, 8'h5A, 1'b0}, 10);
    get_word(3, 9'h5A, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
